// File: rtl/gen_clk_mux_if.sv
// gen_clk_mux_if: host-side control and timing outputs of the clock generator.
//   master : host register file (drives half_cnt/run/step/tap_idx, observes timing)
//   slave  : gen_clk_mux (consumes controls, drives clk_sim/sim_en/indices/strobes)
// Signals:
//   half_cnt   divider half-period minus 1
//   run        1 = free-running, 0 = paused (single-step via step)
//   step       single-step request
//   tap_idx    tap k neuron index in bits [k*IDX_W +: IDX_W]
//   clk_sim    divided level clock
//   sim_en     one-rawclk step enable
//   neuron_idx current neuron index
//   sub_idx    current sub-step
//   frame_stb  frame-start pulse
//   tap_stb    per-tap hit pulses
//   frame_cnt  completed frame counter
interface gen_clk_mux_if #(
  parameter int unsigned IDX_W    = 9,
  parameter int unsigned SUB_W    = 2,
  parameter int unsigned NUM_TAPS = 3
);
  logic [31:0]             half_cnt;
  logic                    run;
  logic                    step;
  logic [NUM_TAPS*IDX_W-1:0] tap_idx;
  logic                    clk_sim;
  logic                    sim_en;
  logic [IDX_W-1:0]        neuron_idx;
  logic [SUB_W-1:0]        sub_idx;
  logic                    frame_stb;
  logic [NUM_TAPS-1:0]     tap_stb;
  logic [31:0]             frame_cnt;

  modport master (
    output half_cnt, run, step, tap_idx,
    input  clk_sim, sim_en, neuron_idx, sub_idx, frame_stb, tap_stb, frame_cnt
  );

  modport slave (
    input  half_cnt, run, step, tap_idx,
    output clk_sim, sim_en, neuron_idx, sub_idx, frame_stb, tap_stb, frame_cnt
  );
endinterface

// File: rtl/gen_clk_mux.sv
// gen_clk_mux: divides rawclk by a runtime half-period into a level sim clock and a
// one-cycle step enable, walks a time-multiplexed neuron index / sub-step counter on
// every step, and emits frame and programmable per-neuron tap strobes. Supports
// run/pause and single-step operation.
// Ports:
//   rawclk  sole clock, all logic on posedge
//   reset   synchronous, active-high
//   bus     gen_clk_mux_if.slave (controls in, timing/index/strobe outputs)
module gen_clk_mux #(
  parameter int unsigned NUM_NEURON = 512,
  parameter int unsigned IDX_W      = 9,
  parameter int unsigned SUB_STEPS  = 4,
  parameter int unsigned SUB_W      = 2,
  parameter int unsigned NUM_TAPS   = 3
) (
  input logic         rawclk,
  input logic         reset,
  gen_clk_mux_if.slave bus
);

  localparam logic [IDX_W-1:0] LastNeuron = IDX_W'(NUM_NEURON - 1);
  localparam logic [SUB_W-1:0] LastSub    = SUB_W'(SUB_STEPS - 1);

  logic [31:0]         delay_cnt_q, delay_cnt_d;
  logic                clk_sim_q, clk_sim_d;
  logic                rise_q, rise_d;
  logic                sim_en_q, sim_en_d;
  logic [IDX_W-1:0]    neuron_q, neuron_d;
  logic [SUB_W-1:0]    sub_q, sub_d;
  logic [31:0]         frame_cnt_q, frame_cnt_d;
  logic                frame_stb_q, frame_stb_d;
  logic [NUM_TAPS-1:0] tap_stb_q, tap_stb_d;

  // Divider: frozen while paused so resuming continues from the held count.
  always_comb begin
    delay_cnt_d = delay_cnt_q;
    clk_sim_d   = clk_sim_q;
    rise_d      = 1'b0;
    if (bus.run) begin
      // ">=" rather than "==" so a shrinking half_cnt toggles on the next cycle.
      if (delay_cnt_q < bus.half_cnt) begin
        delay_cnt_d = delay_cnt_q + 32'd1;
      end else begin
        delay_cnt_d = 32'd0;
        clk_sim_d   = ~clk_sim_q;
        rise_d      = ~clk_sim_q;
      end
    end
  end

  // sim_en lags the clk_sim rising edge by one cycle; step is only honoured when paused.
  always_comb begin
    sim_en_d = rise_q | (~bus.run & bus.step);
  end

  // Index walk and strobes, both from pre-advance values of the sim_en cycle.
  always_comb begin
    neuron_d    = neuron_q;
    sub_d       = sub_q;
    frame_cnt_d = frame_cnt_q;
    frame_stb_d = 1'b0;
    tap_stb_d   = '0;
    if (sim_en_q) begin
      frame_stb_d = (neuron_q == '0) && (sub_q == '0);
      // neuron_q never exceeds LastNeuron, so an out-of-range tap can never match.
      for (int k = 0; k < NUM_TAPS; k++) begin
        tap_stb_d[k] = (sub_q == '0) && (neuron_q == bus.tap_idx[k*IDX_W +: IDX_W]);
      end
      if (sub_q == LastSub) begin
        sub_d = '0;
        if (neuron_q == LastNeuron) begin
          neuron_d    = '0;
          frame_cnt_d = frame_cnt_q + 32'd1;
        end else begin
          neuron_d = neuron_q + IDX_W'(1);
        end
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge rawclk) begin
    if (reset) begin
      delay_cnt_q <= 32'd0;
      clk_sim_q   <= 1'b0;
      rise_q      <= 1'b0;
      sim_en_q    <= 1'b0;
      neuron_q    <= '0;
      sub_q       <= '0;
      frame_cnt_q <= 32'd0;
      frame_stb_q <= 1'b0;
      tap_stb_q   <= '0;
    end else begin
      delay_cnt_q <= delay_cnt_d;
      clk_sim_q   <= clk_sim_d;
      rise_q      <= rise_d;
      sim_en_q    <= sim_en_d;
      neuron_q    <= neuron_d;
      sub_q       <= sub_d;
      frame_cnt_q <= frame_cnt_d;
      frame_stb_q <= frame_stb_d;
      tap_stb_q   <= tap_stb_d;
    end
  end

  assign bus.clk_sim    = clk_sim_q;
  assign bus.sim_en     = sim_en_q;
  assign bus.neuron_idx = neuron_q;
  assign bus.sub_idx    = sub_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.frame_stb  = frame_stb_q;
  assign bus.tap_stb    = tap_stb_q;

endmodule

// File: tb/tb_gen_clk_mux.sv
// Bench for gen_clk_mux: a cycle table from reset, hand sequences for divider timing,
// half_cnt shrink, frame/tap strobes and mid-frame reset, then random stimulus against
// a step-count reference model.
module tb_gen_clk_mux;
  localparam int unsigned NN = 100;
  localparam int unsigned IW = 7;
  localparam int unsigned SS = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned NT = 3;
  localparam longint     FL = longint'(NN) * longint'(SS);

  logic rawclk = 1'b0;
  logic reset  = 1'b1;
  always #5 rawclk = ~rawclk;

  gen_clk_mux_if #(.IDX_W(IW), .SUB_W(SW), .NUM_TAPS(NT)) bus ();

  gen_clk_mux #(
    .NUM_NEURON(NN), .IDX_W(IW), .SUB_STEPS(SS), .SUB_W(SW), .NUM_TAPS(NT)
  ) dut (
    .rawclk(rawclk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rawclk);
    #1;
  endtask

  // Ticks until sim_en is seen; returns edges taken or -1 if the budget expires.
  task automatic wait_en(input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (bus.sim_en !== 1'b1 && cycles < budget);
    if (bus.sim_en !== 1'b1) cycles = -1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0]   m_delay;
  bit            m_clk, m_rose, m_en, m_fstb;
  bit [NT-1:0]   m_tap;
  longint        m_steps;

  task automatic model_tick();
    bit     en_n;
    longint pos;
    longint tv;
    if (reset) begin
      m_delay = 0; m_clk = 0; m_rose = 0; m_en = 0; m_fstb = 0; m_tap = 0; m_steps = 0;
    end else begin
      en_n   = m_rose | (!bus.run && bus.step);
      m_fstb = 0;
      m_tap  = 0;
      if (m_en) begin
        pos    = m_steps % FL;
        m_fstb = (pos == 0);
        for (int k = 0; k < NT; k++) begin
          tv       = longint'(bus.tap_idx[k*IW +: IW]);
          m_tap[k] = (tv < NN) && (pos == tv * SS);
        end
        m_steps++;
      end
      m_rose = 0;
      if (bus.run) begin
        if (m_delay < bus.half_cnt) m_delay = m_delay + 1;
        else begin
          m_delay = 0;
          m_rose  = !m_clk;
          m_clk   = !m_clk;
        end
      end
      m_en = en_n;
    end
  endtask

  task automatic model_compare();
    check("rnd_clk_sim", 64'(bus.clk_sim), 64'(m_clk));
    check("rnd_sim_en", 64'(bus.sim_en), 64'(m_en));
    check("rnd_neuron", 64'(bus.neuron_idx), 64'((m_steps / SS) % NN));
    check("rnd_sub", 64'(bus.sub_idx), 64'(m_steps % SS));
    check("rnd_frame_cnt", 64'(bus.frame_cnt), 64'((m_steps / FL) % 64'h1_0000_0000));
    check("rnd_frame_stb", 64'(bus.frame_stb), 64'(m_fstb));
    check("rnd_tap_stb", 64'(bus.tap_stb), 64'(m_tap));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        run;
    logic        step;
    logic [31:0] half;
    logic        clk;
    logic        en;
    logic        fstb;
    int          sub;
    int          nrn;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int c;
    int en_n, fcnt, t_first, fc_second, tap1_diff, last_f, f_gap;
    int tcnt[NT];
    logic [NT*IW-1:0] taps;

    bus.half_cnt = 32'd1;
    bus.run      = 1'b1;
    bus.step     = 1'b0;
    bus.tap_idx  = '0;

    //          rst run stp half  clk en fstb sub nrn
    vecs[0]  = '{1, 1, 0, 1,    0, 0, 0,   0, 0};
    vecs[1]  = '{0, 1, 0, 1,    0, 0, 0,   0, 0};
    vecs[2]  = '{0, 1, 0, 1,    1, 0, 0,   0, 0};
    vecs[3]  = '{0, 1, 0, 1,    1, 1, 0,   0, 0};
    vecs[4]  = '{0, 1, 0, 1,    0, 0, 1,   1, 0};
    vecs[5]  = '{0, 1, 0, 1,    0, 0, 0,   1, 0};
    vecs[6]  = '{0, 1, 0, 1,    1, 0, 0,   1, 0};
    vecs[7]  = '{0, 1, 0, 1,    1, 1, 0,   1, 0};
    vecs[8]  = '{0, 0, 0, 1,    1, 0, 0,   2, 0};
    vecs[9]  = '{0, 0, 1, 1,    1, 1, 0,   2, 0};
    vecs[10] = '{0, 0, 1, 1,    1, 1, 0,   3, 0};
    vecs[11] = '{0, 0, 0, 1,    1, 0, 0,   0, 1};
    vecs[12] = '{0, 0, 0, 1,    1, 0, 0,   0, 1};
    vecs[13] = '{0, 1, 1, 1,    0, 0, 0,   0, 1};
    vecs[14] = '{0, 1, 1, 1,    0, 0, 0,   0, 1};
    vecs[15] = '{0, 1, 0, 1,    1, 0, 0,   0, 1};
    vecs[16] = '{0, 1, 0, 1,    1, 1, 0,   0, 1};

    for (int i = 0; i < 17; i++) begin
      reset        = vecs[i].rst;
      bus.run      = vecs[i].run;
      bus.step     = vecs[i].step;
      bus.half_cnt = vecs[i].half;
      tick();
      check($sformatf("vec%0d_clk", i), 64'(bus.clk_sim), 64'(vecs[i].clk));
      check($sformatf("vec%0d_en", i), 64'(bus.sim_en), 64'(vecs[i].en));
      check($sformatf("vec%0d_fstb", i), 64'(bus.frame_stb), 64'(vecs[i].fstb));
      check($sformatf("vec%0d_sub", i), 64'(bus.sub_idx), 64'(vecs[i].sub));
      check($sformatf("vec%0d_nrn", i), 64'(bus.neuron_idx), 64'(vecs[i].nrn));
    end

    // Divider half_cnt=3: first sim_en 5 edges after reset, then every 8.
    reset = 1'b1; bus.run = 1'b1; bus.step = 1'b0; bus.half_cnt = 32'd3;
    tick();
    reset = 1'b0;
    wait_en(20, c);
    check("div_first_en", 64'(c), 64'd5);
    wait_en(20, c);
    check("div_period1", 64'(c), 64'd8);
    wait_en(20, c);
    check("div_period2", 64'(c), 64'd8);
    c = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.clk_sim === 1'b1) c++;
    end
    check("div_duty", 64'(c), 64'd8);

    // half_cnt shrink 100 -> 2 with delay at 50.
    reset = 1'b1; bus.half_cnt = 32'd100;
    tick();
    reset = 1'b0;
    repeat (50) tick();
    check("shrink_pre_clk", 64'(bus.clk_sim), 64'd0);
    bus.half_cnt = 32'd2;
    tick();
    check("shrink_toggle", 64'(bus.clk_sim), 64'd1);
    c = 0;
    do begin tick(); c++; end while (bus.clk_sim === 1'b1 && c < 20);
    check("shrink_high", 64'(c), 64'd3);
    c = 0;
    do begin tick(); c++; end while (bus.clk_sim === 1'b0 && c < 20);
    check("shrink_low", 64'(c), 64'd3);

    // Frame/tap strobes over two frames, half_cnt=0. tap0 out of range.
    taps = {7'd5, 7'd0, 7'd120};
    reset = 1'b1; bus.half_cnt = 32'd0; bus.tap_idx = taps;
    tick();
    reset = 1'b0;
    en_n = 0; fcnt = 0; t_first = -1; fc_second = -1; tap1_diff = 0; last_f = -1; f_gap = -1;
    for (int k = 0; k < NT; k++) tcnt[k] = 0;
    c = 0;
    while (en_n < 800 && c < 2000) begin
      tick();
      c++;
      if (bus.tap_stb[1] !== bus.frame_stb) tap1_diff++;
      for (int k = 0; k < NT; k++) if (bus.tap_stb[k] === 1'b1) tcnt[k]++;
      if (bus.tap_stb[2] === 1'b1 && t_first < 0) t_first = en_n;
      if (bus.frame_stb === 1'b1) begin
        fcnt++;
        if (fcnt == 2) begin
          fc_second = int'(bus.frame_cnt);
          f_gap = c - last_f;
        end
        last_f = c;
      end
      if (bus.sim_en === 1'b1) en_n++;
    end
    tick();
    check("frm_budget", 64'(en_n), 64'd800);
    check("frm_tap0_cnt", 64'(tcnt[0]), 64'd0);
    check("frm_tap1_cnt", 64'(tcnt[1]), 64'd2);
    check("frm_tap2_cnt", 64'(tcnt[2]), 64'd2);
    check("frm_fstb_cnt", 64'(fcnt), 64'd2);
    check("frm_tap1_vs_fstb", 64'(tap1_diff), 64'd0);
    check("frm_tap2_first", 64'(t_first), 64'd21);
    check("frm_cnt_second", 64'(fc_second), 64'd1);
    check("frm_gap", 64'(f_gap), 64'd800);
    check("frm_cnt_after2", 64'(bus.frame_cnt), 64'd2);

    // Reset mid-frame at neuron 77.
    c = 0;
    while (bus.neuron_idx !== IW'(77) && c < 1000) begin tick(); c++; end
    check("rst_reach77", 64'(bus.neuron_idx), 64'd77);
    reset = 1'b1;
    tick();
    check("rst_clk", 64'(bus.clk_sim), 64'd0);
    check("rst_en", 64'(bus.sim_en), 64'd0);
    check("rst_nrn", 64'(bus.neuron_idx), 64'd0);
    check("rst_sub", 64'(bus.sub_idx), 64'd0);
    check("rst_fcnt", 64'(bus.frame_cnt), 64'd0);
    check("rst_fstb", 64'(bus.frame_stb), 64'd0);
    check("rst_tap", 64'(bus.tap_stb), 64'd0);
    reset = 1'b0;
    wait_en(10, c);
    check("rst_first_en", 64'(c), 64'd2);
    tick();
    check("rst_first_fstb", 64'(bus.frame_stb), 64'd1);
    check("rst_first_sub", 64'(bus.sub_idx), 64'd1);
    check("rst_first_nrn", 64'(bus.neuron_idx), 64'd0);

    // Random stimulus against the reference model.
    reset = 1'b1; bus.run = 1'b1; bus.step = 1'b0; bus.half_cnt = 32'd1;
    for (int i = 0; i < 6000; i++) begin
      tick();
      model_tick();
      model_compare();
      reset    = ($urandom_range(0, 599) == 0);
      bus.step = $urandom_range(0, 1);
      if ($urandom_range(0, 39) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 99) == 0) bus.half_cnt = $urandom_range(0, 4);
      if ($urandom_range(0, 199) == 0) begin
        for (int k = 0; k < NT; k++) bus.tap_idx[k*IW +: IW] = IW'($urandom_range(0, 127));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
